// File: rtl/hazard_ctrl.sv
// Pipeline sequencing and hazard controller for the five-stage RV32I core.
// Optional build macro HAZARD_FWD_EN enables EX-stage operand forwarding; otherwise RAW hazards stall.
module hazard_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trigger,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic [1:0]       ResultSrcE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic [1:0]       PCSrcE,
  input  logic             HaltE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             running,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned REG_W = 5;
  localparam int unsigned FWD_W = 2;

  localparam logic [FWD_W-1:0] FWD_RF = 2'b00;
  localparam logic [FWD_W-1:0] FWD_W_RES = 2'b01;
  localparam logic [FWD_W-1:0] FWD_M_ALU = 2'b10;
  localparam logic [1:0]       RES_LOAD = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_HALT = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic              ctrl_flush;
  logic              raw_stall;
  logic [FWD_W-1:0]  fwd_a, fwd_b;

  // Hazard detection shared by every state; x0 is never a real dependency.
  always_comb begin
    ctrl_flush = (PCSrcE != 2'b00);
    raw_stall  = 1'b0;
    fwd_a      = FWD_RF;
    fwd_b      = FWD_RF;
`ifdef HAZARD_FWD_EN
    // With forwarding only a load result arrives too late for EX.
    raw_stall = (ResultSrcE == RES_LOAD) && RegWriteE && (RdE != REG_W'(0)) &&
                ((RdE == Rs1D) || (RdE == Rs2D));

    if (RegWriteM && (RdM != REG_W'(0)) && (RdM == Rs1E)) begin
      fwd_a = FWD_M_ALU;
    end else if (RegWriteW && (RdW != REG_W'(0)) && (RdW == Rs1E)) begin
      fwd_a = FWD_W_RES;
    end

    if (RegWriteM && (RdM != REG_W'(0)) && (RdM == Rs2E)) begin
      fwd_b = FWD_M_ALU;
    end else if (RegWriteW && (RdW != REG_W'(0)) && (RdW == Rs2E)) begin
      fwd_b = FWD_W_RES;
    end
`else
    // Without forwarding, wait out any producer still in E or M; W writes the regfile first.
    raw_stall = (RegWriteE && (RdE != REG_W'(0)) && ((RdE == Rs1D) || (RdE == Rs2D))) ||
                (RegWriteM && (RdM != REG_W'(0)) && ((RdM == Rs1D) || (RdM == Rs2D)));
`endif
  end

`ifndef HAZARD_FWD_EN
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{Rs1E, Rs2E, RdW, RegWriteW, ResultSrcE};
`endif

  // Next state, pipeline controls and counter updates.
  always_comb begin
    state_d     = state_q;
    cycle_cnt_d = cycle_cnt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    StallF      = 1'b0;
    StallD      = 1'b0;
    FlushD      = 1'b0;
    FlushE      = 1'b0;
    ForwardAE   = FWD_RF;
    ForwardBE   = FWD_RF;
    running     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushD = 1'b1;
        FlushE = 1'b1;
        if (trigger) begin
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        running     = 1'b1;
        ForwardAE   = fwd_a;
        ForwardBE   = fwd_b;
        cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        // A taken branch squashes the wrong-path D instruction, so it beats any stall.
        if (ctrl_flush) begin
          FlushD      = 1'b1;
          FlushE      = 1'b1;
          flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end else if (raw_stall) begin
          StallF      = 1'b1;
          StallD      = 1'b1;
          FlushE      = 1'b1;
          stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (HaltE && ctrl_flush) begin
          state_d = S_HALT;
        end
      end

      S_HALT: begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cycle_cnt_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cycle_cnt_q <= cycle_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: inputs change on the falling edge, outputs checked 1ns later.
module tb_hazard_ctrl;

  localparam int unsigned CNT_W = 32;
`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst, trigger;
  logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic             RegWriteE, RegWriteM, RegWriteW, HaltE;
  logic [1:0]       ResultSrcE, PCSrcE;
  logic             StallF, StallD, FlushD, FlushE, running;
  logic [1:0]       ForwardAE, ForwardBE;
  logic [CNT_W-1:0] cycle_cnt, stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .trigger(trigger),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .RdM(RdM), .RdW(RdW), .PCSrcE(PCSrcE), .HaltE(HaltE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .running(running),
    .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic fail(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    errors++;
    $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic clear_inputs();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
    RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    ResultSrcE = 2'b00; PCSrcE = 2'b00; HaltE = 1'b0;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; trigger = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    #1;
    checks++; if (StallF !== 1'b1) fail("rst_stallf", 32'(StallF), 32'd1);
    checks++; if (StallD !== 1'b1) fail("rst_stalld", 32'(StallD), 32'd1);
    checks++; if (FlushD !== 1'b1) fail("rst_flushd", 32'(FlushD), 32'd1);
    checks++; if (FlushE !== 1'b1) fail("rst_flushe", 32'(FlushE), 32'd1);
    checks++; if (ForwardAE !== 2'b00) fail("rst_fwda", 32'(ForwardAE), 32'd0);
    checks++; if (running !== 1'b0) fail("rst_running", 32'(running), 32'd0);
    checks++; if (cycle_cnt !== 32'd0) fail("rst_cycle", cycle_cnt, 32'd0);
    rst = 1'b0;

    // Idle with a forwardable pattern present: nothing may forward outside RUN.
    Rs1E = 5'd7; RdM = 5'd7; RegWriteM = 1'b1;
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      checks++; if (StallF !== 1'b1) fail("idle_stallf", 32'(StallF), 32'd1);
      checks++; if (FlushE !== 1'b1) fail("idle_flushe", 32'(FlushE), 32'd1);
      checks++; if (running !== 1'b0) fail("idle_running", 32'(running), 32'd0);
      checks++; if (cycle_cnt !== 32'd0) fail("idle_cycle", cycle_cnt, 32'd0);
      checks++; if (ForwardAE !== 2'b00) fail("idle_fwda", 32'(ForwardAE), 32'd0);
    end

    clear_inputs();
    trigger = 1'b1;
    next_cycle();
    trigger = 1'b0;
    checks++; if (running !== 1'b1) fail("trig_running", 32'(running), 32'd1);
    checks++; if (cycle_cnt !== 32'd0) fail("trig_cycle", cycle_cnt, 32'd0);
    checks++; if (StallF !== 1'b0) fail("run_quiet_stallf", 32'(StallF), 32'd0);
    checks++; if (FlushD !== 1'b0) fail("run_quiet_flushd", 32'(FlushD), 32'd0);
    checks++; if (FlushE !== 1'b0) fail("run_quiet_flushe", 32'(FlushE), 32'd0);

    // Load-use on Rs1D.
    ResultSrcE = 2'b01; RegWriteE = 1'b1; RdE = 5'd5; Rs1D = 5'd5;
    #1;
    checks++; if (StallF !== 1'b1) fail("lu_stallf", 32'(StallF), 32'd1);
    checks++; if (StallD !== 1'b1) fail("lu_stalld", 32'(StallD), 32'd1);
    checks++; if (FlushE !== 1'b1) fail("lu_flushe", 32'(FlushE), 32'd1);
    checks++; if (FlushD !== 1'b0) fail("lu_flushd", 32'(FlushD), 32'd0);

    // Same load targeting x0.
    next_cycle();
    RdE = 5'd0;
    #1;
    checks++; if (stall_cnt !== 32'd1) fail("lu_cnt_stall", stall_cnt, 32'd1);
    checks++; if (cycle_cnt !== 32'd1) fail("lu_cnt_cycle", cycle_cnt, 32'd1);
    checks++; if (StallF !== 1'b0) fail("x0_stallf", 32'(StallF), 32'd0);
    checks++; if (FlushE !== 1'b0) fail("x0_flushe", 32'(FlushE), 32'd0);

    // Branch and load-use together: flush wins.
    next_cycle();
    RdE = 5'd5; PCSrcE = 2'b01;
    #1;
    checks++; if (FlushD !== 1'b1) fail("br_flushd", 32'(FlushD), 32'd1);
    checks++; if (FlushE !== 1'b1) fail("br_flushe", 32'(FlushE), 32'd1);
    checks++; if (StallF !== 1'b0) fail("br_stallf", 32'(StallF), 32'd0);
    checks++; if (StallD !== 1'b0) fail("br_stalld", 32'(StallD), 32'd0);

    next_cycle();
    clear_inputs();
    #1;
    checks++; if (cycle_cnt !== 32'd3) fail("br_cnt_cycle", cycle_cnt, 32'd3);
    checks++; if (stall_cnt !== 32'd1) fail("br_cnt_stall", stall_cnt, 32'd1);
    checks++; if (flush_cnt !== 32'd1) fail("br_cnt_flush", flush_cnt, 32'd1);

    // Forwarding: M over W, then W alone.
    Rs1E = 5'd7; RdM = 5'd7; RdW = 5'd7; RegWriteM = 1'b1; RegWriteW = 1'b1;
    #1;
    checks++; if (ForwardAE !== (FWD ? 2'b10 : 2'b00)) fail("fwd_m", 32'(ForwardAE), FWD ? 32'd2 : 32'd0);
    checks++; if (ForwardBE !== 2'b00) fail("fwd_m_b", 32'(ForwardBE), 32'd0);
    checks++; if (StallF !== 1'b0) fail("fwd_m_stallf", 32'(StallF), 32'd0);
    RegWriteM = 1'b0; Rs2E = 5'd7;
    #1;
    checks++; if (ForwardAE !== (FWD ? 2'b01 : 2'b00)) fail("fwd_w", 32'(ForwardAE), FWD ? 32'd1 : 32'd0);
    checks++; if (ForwardBE !== (FWD ? 2'b01 : 2'b00)) fail("fwd_w_b", 32'(ForwardBE), FWD ? 32'd1 : 32'd0);

    // x0 never forwards.
    next_cycle();
    clear_inputs();
    RegWriteM = 1'b1; RegWriteW = 1'b1;
    #1;
    checks++; if (ForwardAE !== 2'b00) fail("fwd_x0", 32'(ForwardAE), 32'd0);
    // M-stage producer read in D: stalls only without forwarding.
    RdM = 5'd3; Rs2D = 5'd3;
    #1;
    checks++; if (StallF !== !FWD) fail("rawm_stallf", 32'(StallF), 32'(!FWD));
    checks++; if (FlushE !== !FWD) fail("rawm_flushe", 32'(FlushE), 32'(!FWD));

    // Non-load E-stage producer read in D: stalls only without forwarding.
    next_cycle();
    clear_inputs();
    RegWriteE = 1'b1; RdE = 5'd9; Rs1D = 5'd9;
    #1;
    checks++; if (StallD !== !FWD) fail("rawe_stalld", 32'(StallD), 32'(!FWD));

    // Halt flag without a taken jump does not halt.
    next_cycle();
    clear_inputs();
    HaltE = 1'b1;
    #1;
    checks++; if (stall_cnt !== (FWD ? 32'd1 : 32'd3)) fail("raw_cnt_stall", stall_cnt, FWD ? 32'd1 : 32'd3);
    checks++; if (cycle_cnt !== 32'd6) fail("raw_cnt_cycle", cycle_cnt, 32'd6);

    next_cycle();
    checks++; if (running !== 1'b1) fail("nohalt_running", 32'(running), 32'd1);
    PCSrcE = 2'b01;
    #1;
    checks++; if (FlushD !== 1'b1) fail("halt_flushd", 32'(FlushD), 32'd1);

    next_cycle();
    clear_inputs();
    trigger = 1'b1;
    ResultSrcE = 2'b01; RegWriteE = 1'b1; RdE = 5'd5; Rs1D = 5'd5;
    #1;
    checks++; if (running !== 1'b0) fail("halt_running", 32'(running), 32'd0);
    checks++; if (StallF !== 1'b1) fail("halt_stallf", 32'(StallF), 32'd1);
    checks++; if (FlushD !== 1'b0) fail("halt_flushd", 32'(FlushD), 32'd0);
    checks++; if (FlushE !== 1'b1) fail("halt_flushe", 32'(FlushE), 32'd1);
    checks++; if (cycle_cnt !== 32'd8) fail("halt_cycle", cycle_cnt, 32'd8);
    checks++; if (flush_cnt !== 32'd2) fail("halt_flush_cnt", flush_cnt, 32'd2);
    repeat (3) next_cycle();
    checks++; if (running !== 1'b0) fail("halt_hold_running", 32'(running), 32'd0);
    checks++; if (cycle_cnt !== 32'd8) fail("halt_hold_cycle", cycle_cnt, 32'd8);
    checks++; if (stall_cnt !== (FWD ? 32'd1 : 32'd3)) fail("halt_hold_stall", stall_cnt, FWD ? 32'd1 : 32'd3);

    rst = 1'b1; trigger = 1'b0;
    clear_inputs();
    next_cycle();
    rst = 1'b0;
    checks++; if (running !== 1'b0) fail("rst2_running", 32'(running), 32'd0);
    checks++; if (FlushD !== 1'b1) fail("rst2_flushd", 32'(FlushD), 32'd1);
    checks++; if (cycle_cnt !== 32'd0) fail("rst2_cycle", cycle_cnt, 32'd0);
    checks++; if (flush_cnt !== 32'd0) fail("rst2_flush", flush_cnt, 32'd0);

    // Restart, run two cycles, then reset mid-run with a trigger present.
    trigger = 1'b1;
    next_cycle();
    checks++; if (running !== 1'b1) fail("rerun_running", 32'(running), 32'd1);
    repeat (2) next_cycle();
    checks++; if (cycle_cnt !== 32'd2) fail("rerun_cycle", cycle_cnt, 32'd2);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0; trigger = 1'b0;
    checks++; if (running !== 1'b0) fail("midrst_running", 32'(running), 32'd0);
    checks++; if (cycle_cnt !== 32'd0) fail("midrst_cycle", cycle_cnt, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
